// File: rtl/exp_shifter_gen2_if.sv
// Sample stream bundle: {I,Q} payload, sideband tuser, tlast, ready/valid handshake.
interface exp_shifter_gen2_if #(
   parameter int DATA_W  = 16,
   parameter int TUSER_W = 24
);
   logic                tvalid;
   logic [2*DATA_W-1:0] tdata;
   logic [TUSER_W-1:0]  tuser;
   logic                tlast;
   logic                tready;

   modport master (output tvalid, tdata, tuser, tlast, input tready);
   modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/exp_shifter_gen2.sv
// Block-floating-point exponent normaliser: per-block shift from an averaged exponent,
// saturating shift of each I/Q component, first-word-fall-through output FIFO.
module exp_shifter_gen2_lane #(
   parameter int DATA_W = 16,
   parameter int SH_W   = 4,
   parameter int WW     = 24
) (
   input  logic [DATA_W-1:0]      din,
   input  logic signed [SH_W-1:0] sh,
   output logic [DATA_W-1:0]      dout,
   output logic                   sat
);
   localparam logic signed [WW-1:0] POS_MAX = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [WW-1:0] NEG_MIN = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic [SH_W-1:0]      mag;
   logic signed [WW-1:0] xw, rnd, r;

   always_comb begin
      mag  = sh[SH_W-1] ? $unsigned(-sh) : $unsigned(sh);
      xw   = {{(WW-DATA_W){din[DATA_W-1]}}, din};
      rnd  = '0;
      if (sh[SH_W-1]) begin
         // round half up: add half an LSB of the result before the arithmetic shift
         rnd = WW'(1) <<< (mag - SH_W'(1));
         r   = (xw + rnd) >>> mag;
      end else begin
         r   = xw <<< mag;
      end
      sat  = 1'b0;
      dout = r[DATA_W-1:0];
      if (r > POS_MAX) begin
         dout = POS_MAX[DATA_W-1:0];
         sat  = 1'b1;
      end else if (r < NEG_MIN) begin
         dout = NEG_MIN[DATA_W-1:0];
         sat  = 1'b1;
      end
   end
endmodule

module exp_shifter_gen2 #(
   parameter int DATA_W      = 16,
   parameter int TUSER_W     = 24,
   parameter int BIN_W       = 11,
   parameter int EXP_LSB     = 16,
   parameter int EXP_W       = 5,
   parameter int HEAD_ROOM   = 2,
   parameter int MAX_SHIFT   = 7,
   parameter int FIFO_ADDR_W = 6,
   parameter int AF_THRESH   = 16
) (
   input  logic                     clk,
   input  logic                     sync_reset,
   exp_shifter_gen2_if.slave        s_axis,
   input  logic [3:0]               avg_shift,
   input  logic                     bypass,
   input  logic                     sat_clear,
   output logic                     sat_flag,
   output logic                     eob_tag,
   exp_shifter_gen2_if.master       m_axis
);
   localparam int NUM_LANES = 2;
   localparam int STAGES    = 3;
   localparam int SH_W      = $clog2(MAX_SHIFT+1) + 1;
   localparam int WW        = DATA_W + MAX_SHIFT + 1;
   localparam int AVG_W     = EXP_W + 8;
   localparam int SR_W      = EXP_W + 3;
   localparam int DEPTH     = 1 << FIFO_ADDR_W;
   localparam int FC_W      = FIFO_ADDR_W + 2;

   typedef struct packed {
      logic [2*DATA_W-1:0] data;
      logic [TUSER_W-1:0]  user;
      logic                last;
   } beat_t;
   typedef struct packed {
      beat_t            b;
      logic             start;
      logic [EXP_W-1:0] e;
      logic [3:0]       ash;
      logic             byp;
   } st1_t;
   typedef struct packed {
      beat_t                 b;
      logic signed [SH_W-1:0] sh;
   } st2_t;

   logic [STAGES:1]        vld_pipe_q, vld_pipe_d;
   st1_t                   st1_q, st1_d;
   st2_t                   st2_q, st2_d;
   beat_t                  st3_q, st3_d;
   logic [AVG_W-1:0]       avg_q, avg_d;
   logic                   first_q, first_d;
   logic signed [SH_W-1:0] blk_s_q, blk_s_d;
   logic                   sat_flag_q, sat_flag_d;
   logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_ADDR_W:0]   cnt_q, cnt_d;
   beat_t                  mem_q [DEPTH];

   logic                   ready, take, blk_start, wr_en, rd_en, out_vld;
   logic [FC_W-1:0]        in_flight, free_ent;
   logic [EXP_W-1:0]       avg_floor;
   logic signed [SR_W-1:0] s_raw;
   logic signed [SH_W-1:0] s_new, sh2;
   logic [3:0]             ash_c;
   logic signed [AVG_W+1:0] diff, delta, sum;
   logic [1:0]             unused_sum_hi;
   beat_t                  head;

   logic [NUM_LANES-1:0][DATA_W-1:0] lane_in, lane_out;
   logic [NUM_LANES-1:0]             lane_sat;

   // admission counts samples still in the pipeline so the FIFO can never overflow
   always_comb begin
      in_flight = '0;
      for (int i = 1; i <= STAGES; i++) in_flight = in_flight + FC_W'(vld_pipe_q[i]);
      free_ent  = FC_W'(DEPTH) - FC_W'(cnt_q) - in_flight;
      ready     = free_ent > FC_W'(AF_THRESH);
      take      = s_axis.tvalid & ready;
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], take};
   end
   assign s_axis.tready = ready;

   always_comb begin
      st1_d = st1_q;
      if (take) begin
         st1_d.b.data = s_axis.tdata;
         st1_d.b.user = s_axis.tuser;
         st1_d.b.last = s_axis.tlast;
         st1_d.start  = (s_axis.tuser[BIN_W-1:0] == '0);
         st1_d.e      = s_axis.tuser[EXP_LSB +: EXP_W];
         st1_d.ash    = avg_shift;
         st1_d.byp    = bypass;
      end
   end

   // the very first block sees the averager already loaded with its own exponent
   always_comb begin
      blk_start = vld_pipe_q[1] & st1_q.start;
      avg_floor = first_q ? st1_q.e : avg_q[AVG_W-1:8];
      s_raw     = $signed({3'b000, st1_q.e}) - $signed({3'b000, avg_floor}) - SR_W'(HEAD_ROOM);
      if (s_raw > SR_W'(MAX_SHIFT))       s_new = SH_W'(MAX_SHIFT);
      else if (s_raw < -SR_W'(MAX_SHIFT)) s_new = -SH_W'(MAX_SHIFT);
      else                                s_new = s_raw[SH_W-1:0];
      if (st1_q.byp) s_new = '0;
      sh2     = blk_start ? s_new : blk_s_q;
      blk_s_d = sh2;

      ash_c = (st1_q.ash > 4'd8) ? 4'd8 : st1_q.ash;
      diff  = $signed({2'b00, st1_q.e, 8'h00}) - $signed({2'b00, avg_q});
      delta = diff >>> ash_c;
      sum   = $signed({2'b00, avg_q}) + delta;
      unused_sum_hi = sum[AVG_W+1:AVG_W];
      avg_d   = avg_q;
      first_d = first_q;
      if (blk_start) begin
         avg_d   = first_q ? {st1_q.e, 8'h00} : sum[AVG_W-1:0];
         first_d = 1'b0;
      end

      st2_d = st2_q;
      if (vld_pipe_q[1]) begin
         st2_d.b  = st1_q.b;
         st2_d.sh = sh2;
      end
   end

   assign lane_in = st2_q.b.data;
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      exp_shifter_gen2_lane #(.DATA_W(DATA_W), .SH_W(SH_W), .WW(WW)) u_lane (
         .din  (lane_in[g]),
         .sh   (st2_q.sh),
         .dout (lane_out[g]),
         .sat  (lane_sat[g])
      );
   end

   always_comb begin
      st3_d      = st3_q;
      sat_flag_d = sat_flag_q;
      if (vld_pipe_q[2]) begin
         st3_d      = st2_q.b;
         st3_d.data = lane_out;
      end
      if (sat_clear) sat_flag_d = 1'b0;
      if (vld_pipe_q[2] && |lane_sat) sat_flag_d = 1'b1;
   end

   always_comb begin
      out_vld  = (cnt_q != '0);
      wr_en    = vld_pipe_q[STAGES];
      rd_en    = out_vld & m_axis.tready;
      wr_ptr_d = wr_ptr_q + FIFO_ADDR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + FIFO_ADDR_W'(rd_en);
      cnt_d    = cnt_q + (FIFO_ADDR_W+1)'(wr_en) - (FIFO_ADDR_W+1)'(rd_en);
      head     = out_vld ? mem_q[rd_ptr_q] : '0;
   end

   assign m_axis.tvalid = out_vld;
   assign m_axis.tdata  = head.data;
   assign m_axis.tuser  = head.user;
   assign m_axis.tlast  = head.last;
   assign eob_tag       = head.user[TUSER_W-1];
   assign sat_flag      = sat_flag_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= st3_q;
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         vld_pipe_q <= '0;
         st1_q      <= '0;
         st2_q      <= '0;
         st3_q      <= '0;
         avg_q      <= '0;
         first_q    <= 1'b1;
         blk_s_q    <= '0;
         sat_flag_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         st1_q      <= st1_d;
         st2_q      <= st2_d;
         st3_q      <= st3_d;
         avg_q      <= avg_d;
         first_q    <= first_d;
         blk_s_q    <= blk_s_d;
         sat_flag_q <= sat_flag_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end
endmodule

// File: tb/tb_exp_shifter_gen2.sv
// Directed bench for exp_shifter_gen2: hand-computed shifts, latency, saturation, backpressure.
module tb_exp_shifter_gen2;
   localparam int DATA_W  = 16;
   localparam int TUSER_W = 24;
   localparam int WORD_W  = 2*DATA_W + TUSER_W + 1;

   logic clk = 1'b0;
   logic sync_reset = 1'b1;
   logic [3:0] avg_shift = 4'd0;
   logic bypass = 1'b0, sat_clear = 1'b0;
   logic sat_flag, eob_tag;
   int checks = 0, fails = 0;
   logic [WORD_W-1:0] cap_q[$], exp_q[$];

   always #5 clk = ~clk;

   exp_shifter_gen2_if #(.DATA_W(DATA_W), .TUSER_W(TUSER_W)) s_if ();
   exp_shifter_gen2_if #(.DATA_W(DATA_W), .TUSER_W(TUSER_W)) m_if ();

   exp_shifter_gen2 dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .s_axis     (s_if),
      .avg_shift  (avg_shift),
      .bypass     (bypass),
      .sat_clear  (sat_clear),
      .sat_flag   (sat_flag),
      .eob_tag    (eob_tag),
      .m_axis     (m_if)
   );

   always @(negedge clk)
      if (!sync_reset && m_if.tvalid && m_if.tready)
         cap_q.push_back({m_if.tdata, m_if.tuser, m_if.tlast});

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [TUSER_W-1:0] mk_user(input logic eob, input logic [4:0] e,
                                                  input logic [10:0] bin);
      return {eob, 2'b00, e, 5'b00000, bin};
   endfunction

   task automatic do_reset();
      sync_reset = 1'b1;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
      sat_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 sync_reset = 1'b0;
      cap_q.delete();
      exp_q.delete();
   endtask

   task automatic send(input logic [31:0] d, input logic [TUSER_W-1:0] u, input logic l,
                       input logic [31:0] ed);
      int n = 0;
      logic t = 1'b0;
      s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = u; s_if.tlast = l;
      do begin
         @(negedge clk); t = s_if.tready;
         @(posedge clk); #1; n++;
      end while (!t && n < 200);
      s_if.tvalid = 1'b0;
      if (!t) chk("send_timeout", 64'd0, 64'd1);
      else    exp_q.push_back({ed, u, l});
   endtask

   task automatic drain_check(input string tag);
      int n = 0;
      while (cap_q.size() < exp_q.size() && n < 1000) begin @(posedge clk); n++; end
      repeat (10) @(posedge clk);
      #1;
      chk({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), (i < cap_q.size()) ? 64'(cap_q[i]) : 64'hDEAD,
             64'(exp_q[i]));
      cap_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int n, taken;
      logic t;
      logic [15:0] k;
      logic [31:0] d;
      logic [TUSER_W-1:0] u;
      logic l;
      m_if.tready = 1'b1;

      // reset state
      do_reset();
      chk("rst_tready", s_if.tready, 1);
      chk("rst_tvalid", m_if.tvalid, 0);
      chk("rst_tdata",  m_if.tdata, 0);
      chk("rst_tuser",  m_if.tuser, 0);
      chk("rst_tlast",  m_if.tlast, 0);
      chk("rst_sat",    sat_flag, 0);
      chk("rst_eob",    eob_tag, 0);

      // first block e=5 -> s=-2, visible take+4
      send(32'h0100_0100, mk_user(1'b1, 5'd5, 11'd0), 1'b1, 32'h0040_0040);
      n = 0;
      while (!m_if.tvalid && n < 20) begin @(posedge clk); #1; n++; end
      chk("lat", 64'(n), 64'd3);
      chk("first_data", m_if.tdata, 32'h0040_0040);
      chk("first_eob", eob_tag, 1);
      drain_check("t027");

      // averager with avg_shift=0 tracks the exponent immediately
      do_reset();
      avg_shift = 4'd0;
      send(32'h0100_0100, mk_user(1'b0, 5'd3, 11'd0), 1'b0, 32'h0040_0040);
      send(32'h0100_0100, mk_user(1'b1, 5'd0, 11'd1), 1'b1, 32'h0040_0040);
      send(32'h0100_0100, mk_user(1'b0, 5'd6, 11'd0), 1'b0, 32'h0200_0200);
      send(32'h0080_0080, mk_user(1'b1, 5'd0, 11'd1), 1'b1, 32'h0100_0100);
      send(32'h0100_0100, mk_user(1'b0, 5'd6, 11'd0), 1'b0, 32'h0040_0040);
      drain_check("t028");

      // s=+3 saturation and sticky flag, then s=-2 with rounding
      do_reset();
      send(32'h0100_0100, mk_user(1'b0, 5'd0, 11'd0), 1'b0, 32'h0040_0040);
      drain_check("t029a");
      chk("sat_before", sat_flag, 0);
      send(32'h2000_E000, mk_user(1'b0, 5'd5, 11'd0), 1'b0, 32'h7FFF_8000);
      drain_check("t029b");
      chk("sat_set", sat_flag, 1);
      repeat (5) @(posedge clk);
      #1 chk("sat_hold", sat_flag, 1);
      sat_clear = 1'b1;
      @(posedge clk); #1 sat_clear = 1'b0;
      chk("sat_clr", sat_flag, 0);
      send(32'h0006_FFFA, mk_user(1'b0, 5'd5, 11'd0), 1'b0, 32'h0002_FFFF);
      drain_check("t030");
      chk("sat_stay", sat_flag, 0);

      // reset with a sample in flight: nothing emerges
      do_reset();
      send(32'h1234_5678, mk_user(1'b0, 5'd4, 11'd0), 1'b0, 32'h0);
      sync_reset = 1'b1;
      @(posedge clk); #1 sync_reset = 1'b0;
      cap_q.delete(); exp_q.delete();
      repeat (10) @(posedge clk);
      #1;
      chk("inflight_discard", 64'(cap_q.size()), 64'd0);
      chk("inflight_tvalid", m_if.tvalid, 0);

      // backpressure: bypass block, stall until admission stops at 48 samples
      do_reset();
      m_if.tready = 1'b0; bypass = 1'b1; avg_shift = 4'd8;
      taken = 0;
      for (int c = 0; c < 80; c++) begin
         k = 16'(taken);
         d = {(k * 16'h0123) ^ 16'h8001, ~(k * 16'h0101)};
         u = mk_user(taken == 47, 5'(taken), 11'(taken));
         l = (taken % 8 == 7);
         s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = u; s_if.tlast = l;
         @(negedge clk); t = s_if.tready;
         @(posedge clk); #1;
         if (t) begin exp_q.push_back({d, u, l}); taken++; end
      end
      s_if.tvalid = 1'b0;
      chk("bp_taken", 64'(taken), 64'd48);
      chk("bp_tready", s_if.tready, 0);
      chk("bp_tvalid", m_if.tvalid, 1);
      chk("bp_hold", {m_if.tdata, m_if.tuser, m_if.tlast}, 64'(exp_q[0]));
      m_if.tready = 1'b1;
      drain_check("t031");
      chk("bp_tready_back", s_if.tready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/exp_shifter_gen2.md
EXP_SHIFTER_GEN2 -- requirements
Module: exp_shifter_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 16, I/Q component width.
REQ-002 SHALL have parameter TUSER_W, default 24, sideband width; bit TUSER_W-1 = end-of-block tag.
REQ-003 SHALL have parameter BIN_W, default 11, FFT bin index field in tuser[BIN_W-1:0].
REQ-004 SHALL have parameter EXP_LSB, default 16, LSB of block exponent field in tuser.
REQ-005 SHALL have parameter EXP_W, default 5, unsigned block exponent width.
REQ-006 SHALL have parameter HEAD_ROOM, default 2, bits of headroom subtracted from every block shift.
REQ-007 SHALL have parameter MAX_SHIFT, default 7, magnitude clamp on applied shift.
REQ-008 SHALL have parameter FIFO_ADDR_W, default 6, output FIFO depth 2^FIFO_ADDR_W.
REQ-009 SHALL have parameter AF_THRESH, default 16, free-entry threshold for deasserting s_axis_tready.
REQ-010 SHALL have ports: clk in 1 clock; sync_reset in 1 reset; s_axis_tvalid in 1; s_axis_tdata in 2*DATA_W {I,Q}; s_axis_tuser in TUSER_W; s_axis_tlast in 1; s_axis_tready out 1; avg_shift in 4 averager coefficient (0..8); bypass in 1 force shift 0; sat_clear in 1; sat_flag out 1 sticky saturation; eob_tag out 1; m_axis_tvalid out 1; m_axis_tdata out 2*DATA_W; m_axis_tuser out TUSER_W; m_axis_tlast out 1; m_axis_tready in 1.
REQ-011 Reset SHALL be sync_reset, asynchronous, active-high; clock SHALL be clk.

Function
REQ-012 take = s_axis_tvalid & s_axis_tready; s_axis_tready SHALL be 1 while FIFO free entries (including pipeline in flight) > AF_THRESH, else 0.
REQ-013 Every taken sample SHALL be written to the FIFO exactly 3 cycles after take; FIFO SHALL be first-word-fall-through, so m_axis_tvalid rises no earlier than take+4; order preserved, no drop, no duplication.
REQ-014 tuser and tlast SHALL pass unchanged; eob_tag = m_axis_tuser[TUSER_W-1] combinationally.
REQ-015 Block start = take with tuser bin field == 0; exponent e = tuser[EXP_LSB+:EXP_W] of that sample.
REQ-016 Averager avg: unsigned EXP_W.8 fixed point; first block start after reset loads avg = e<<8; thereafter avg <= avg + (((e<<8) - avg) >>> avg_shift), signed arithmetic; avg_shift > 8 treated as 8.
REQ-017 Block shift s = e - floor(avg before this block's update) - HEAD_ROOM, signed, clamped to [-MAX_SHIFT, +MAX_SHIFT]; bypass=1 forces s = 0 (averager still updates).
REQ-018 s SHALL apply to the block-start sample and all following samples until next block start; samples taken before first block start after reset use s = 0.
REQ-019 s > 0: left shift by s, saturating to [-2^(DATA_W-1), 2^(DATA_W-1)-1] per component.
REQ-020 s < 0: arithmetic right shift by |s| with round-half-up (add 2^(|s|-1) then shift), saturating at positive max.
REQ-021 Any component saturation SHALL set sat_flag the cycle after the output is computed; sat_flag held until sat_clear=1; simultaneous set and clear -> set wins.
REQ-022 avg_shift and bypass SHALL be sampled at block start only; mid-block changes take effect at the next block.
REQ-023 m_axis_* SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-024 On sync_reset: FIFO and pipeline emptied, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, sat_flag=0, avg cleared with first-block flag re-armed, s=0; s_axis_tready=1 first cycle after release.
REQ-025 Reset mid-block SHALL discard in-flight samples; no partial output after release.

Verification
REQ-026 Reset, no input -> tready=1, m_axis_tvalid=0, sat_flag=0, all outputs 0.
REQ-027 First block after reset, e=5, I=Q=0x0100 -> s=-2, outputs 0x0040, first m_axis_tvalid at take+4.
REQ-028 avg_shift=0, block A e=3, block B e=6, data 0x0100 -> block B s=+1, output 0x0200; block C e=6 -> s=-2, output 0x0040.
REQ-029 s=+3 on I=0x2000, Q=0xE000 -> I=0x7FFF, Q=0x8000, sat_flag=1 until sat_clear pulse.
REQ-030 s=-2 on I=0x0006, Q=0xFFFA -> I=0x0002, Q=0xFFFF, sat_flag unchanged.
REQ-031 m_axis_tready=0 with continuous input -> tready drops when free entries reach AF_THRESH; release -> all samples out in order, tlast/tuser intact, bypass=1 block output equals input.
